// File: rtl/pulse_channel_gen2_pkg.sv
// rtl/pulse_channel_gen2_pkg.sv - shared APU tables, register indices and duty lookup
//
// Purpose: constants shared by the pulse channel and its envelope (the noise
// channel reuses the same tables and envelope).
//   reg_addr_e    register index decode for wr_addr
//   R*_*          bit positions of register fields inside wr_data
//   LENGTH_TABLE  8-bit length counter load values, indexed by len_idx
//   DUTY_TABLE    8-step duty patterns, indexed by duty then sequencer index
`timescale 1ns/1ps
package pulse_channel_gen2_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_SWEEP  = 2'd1,
    REG_PER_LO = 2'd2,
    REG_PER_HI = 2'd3
  } reg_addr_e;

  localparam int R0_DUTY_HI  = 7;
  localparam int R0_DUTY_LO  = 6;
  localparam int R0_HALT     = 5;
  localparam int R0_CONST    = 4;

  localparam int R1_SW_EN    = 7;
  localparam int R1_PER_HI   = 6;
  localparam int R1_PER_LO   = 4;
  localparam int R1_NEG      = 3;
  localparam int R1_SHIFT_HI = 2;
  localparam int R1_SHIFT_LO = 0;

  localparam int R3_LEN_HI   = 7;
  localparam int R3_LEN_LO   = 3;

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b0000_0010,
    8'b0000_0110,
    8'b0001_1110,
    8'b1111_1001
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] idx);
    logic [7:0] pattern;
    pattern = DUTY_TABLE[duty];
    return pattern[idx];
  endfunction

endpackage

// File: rtl/pulse_channel_gen2_if.sv
// rtl/pulse_channel_gen2_if.sv - frame ticks, register write bus and sample output of one pulse voice
//
// Purpose: bundles everything except clock and reset.
//   qtr_en / hlf_en   one-cycle frame-sequencer ticks
//   wr_en/addr/data   register write strobe, index 0..3 and data byte
//   ch_enable         status-register enable for this voice
//   pulse_out         signed sample (OUT_W bits)
//   len_active        length counter non-zero
// Modports: master drives ticks/writes, slave is the channel.
`timescale 1ns/1ps
interface pulse_channel_gen2_if #(
  parameter int OUT_W = 5
) ();

  logic                    qtr_en;
  logic                    hlf_en;
  logic                    wr_en;
  logic [1:0]              wr_addr;
  logic [7:0]              wr_data;
  logic                    ch_enable;
  logic signed [OUT_W-1:0] pulse_out;
  logic                    len_active;

  modport master (
    output qtr_en, hlf_en, wr_en, wr_addr, wr_data, ch_enable,
    input  pulse_out, len_active
  );

  modport slave (
    input  qtr_en, hlf_en, wr_en, wr_addr, wr_data, ch_enable,
    output pulse_out, len_active
  );

endinterface

// File: rtl/pulse_channel_gen2_envelope.sv
// rtl/pulse_channel_gen2_envelope.sv - APU volume envelope (decay counter with divider and loop)
//
// Purpose: produces the channel volume from either the constant volume or a
// decaying counter clocked by quarter-frame ticks.
// Ports:
//   apu_clk, rst_n   clock, asynchronous active-low reset
//   i_qtr_en         quarter-frame tick
//   i_start          one-cycle restart request (length/period-high write)
//   i_halt           loop flag: decay wraps from 0 back to all-ones
//   i_const_vol      1: output i_vol directly
//   i_vol            constant volume / divider reload value
//   o_volume         current volume
`timescale 1ns/1ps
module pulse_channel_gen2_envelope #(
  parameter int VOL_W = 4
) (
  input  logic             apu_clk,
  input  logic             rst_n,
  input  logic             i_qtr_en,
  input  logic             i_start,
  input  logic             i_halt,
  input  logic             i_const_vol,
  input  logic [VOL_W-1:0] i_vol,
  output logic [VOL_W-1:0] o_volume
);

  logic             r_start;
  logic [VOL_W-1:0] r_decay;
  logic [VOL_W-1:0] r_div;

  // The start request is latched and only consumed by the next quarter tick;
  // a new request in the same cycle as that tick keeps the flag set.
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 1'b0;
    end else if (i_start) begin
      r_start <= 1'b1;
    end else if (i_qtr_en) begin
      r_start <= 1'b0;
    end
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decay <= '0;
      r_div   <= '0;
    end else if (i_qtr_en) begin
      if (r_start) begin
        r_decay <= '1;
        r_div   <= i_vol;
      end else if (r_div == '0) begin
        r_div <= i_vol;
        if (r_decay != '0) begin
          r_decay <= r_decay - VOL_W'(1);
        end else if (i_halt) begin
          r_decay <= '1;
        end
      end else begin
        r_div <= r_div - VOL_W'(1);
      end
    end
  end

  assign o_volume = i_const_vol ? i_vol : r_decay;

endmodule

// File: rtl/pulse_channel_gen2.sv
// rtl/pulse_channel_gen2.sv - APU pulse voice: timer, duty sequencer, sweep, length, envelope
//
// Purpose: one square-wave voice in the apu_clk domain. NEG_ONES_COMP picks the
// pulse-1 (one's complement) or pulse-2 (two's complement) sweep negate.
// Ports:
//   apu_clk   APU clock
//   rst_n     asynchronous active-low reset
//   bus       pulse_channel_gen2_if.slave: ticks, register writes, ch_enable,
//             pulse_out (registered, 1-cycle latency), len_active
`timescale 1ns/1ps
module pulse_channel_gen2
  import pulse_channel_gen2_pkg::*;
#(
  parameter int TIMER_W       = 11,
  parameter int VOL_W         = 4,
  parameter int OUT_W         = 5,
  parameter int NEG_ONES_COMP = 0,
  parameter int MIN_PERIOD    = 8
) (
  input  logic                 apu_clk,
  input  logic                 rst_n,
  pulse_channel_gen2_if.slave  bus
);

  localparam logic [TIMER_W-1:0] MIN_P = TIMER_W'(MIN_PERIOD);
  localparam logic [TIMER_W:0]   ONE_X = {{TIMER_W{1'b0}}, 1'b1};

  // Register fields
  logic [1:0]         r_duty;
  logic               r_halt;
  logic               r_const_vol;
  logic [VOL_W-1:0]   r_vol;
  logic               r_sw_en;
  logic [2:0]         r_sw_per;
  logic               r_sw_neg;
  logic [2:0]         r_sw_shift;
  logic [TIMER_W-1:0] r_period;

  // Channel state
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_seq_idx;
  logic [7:0]         r_length;
  logic [2:0]         r_sw_div;
  logic               r_sw_reload;
  logic [OUT_W-1:0]   r_out;

  logic               w_wr_r0;
  logic               w_wr_r1;
  logic               w_wr_r2;
  logic               w_wr_r3;
  logic [TIMER_W:0]   w_period_x;
  logic [TIMER_W:0]   w_delta;
  logic [TIMER_W:0]   w_target;
  logic               w_mute;
  logic               w_sweep_apply;
  logic               w_seq_bit;
  logic [VOL_W-1:0]   w_volume;
  logic [OUT_W-1:0]   w_mag;
  logic [OUT_W-1:0]   w_sample;

  assign w_wr_r0 = bus.wr_en && (bus.wr_addr == REG_CTRL);
  assign w_wr_r1 = bus.wr_en && (bus.wr_addr == REG_SWEEP);
  assign w_wr_r2 = bus.wr_en && (bus.wr_addr == REG_PER_LO);
  assign w_wr_r3 = bus.wr_en && (bus.wr_addr == REG_PER_HI);

  // Control and sweep registers
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty      <= '0;
      r_halt      <= 1'b0;
      r_const_vol <= 1'b0;
      r_vol       <= '0;
      r_sw_en     <= 1'b0;
      r_sw_per    <= '0;
      r_sw_neg    <= 1'b0;
      r_sw_shift  <= '0;
    end else begin
      if (w_wr_r0) begin
        r_duty      <= bus.wr_data[R0_DUTY_HI:R0_DUTY_LO];
        r_halt      <= bus.wr_data[R0_HALT];
        r_const_vol <= bus.wr_data[R0_CONST];
        r_vol       <= bus.wr_data[VOL_W-1:0];
      end
      if (w_wr_r1) begin
        r_sw_en    <= bus.wr_data[R1_SW_EN];
        r_sw_per   <= bus.wr_data[R1_PER_HI:R1_PER_LO];
        r_sw_neg   <= bus.wr_data[R1_NEG];
        r_sw_shift <= bus.wr_data[R1_SHIFT_HI:R1_SHIFT_LO];
      end
    end
  end

  // Sweep target, computed one bit wider so the add carry is visible
  assign w_period_x = {1'b0, r_period};
  assign w_delta    = {1'b0, r_period >> r_sw_shift};

  always_comb begin
    w_target = w_period_x + w_delta;
    if (r_sw_neg) begin
      if (NEG_ONES_COMP != 0) begin
        w_target = w_period_x - w_delta - ONE_X;
      end else begin
        w_target = w_period_x - w_delta;
      end
    end
  end

  // The carry only means overflow in add mode; in negate mode bit TIMER_W is a borrow.
  assign w_mute = (r_period < MIN_P)
                | (!r_sw_neg && w_target[TIMER_W])
                | (r_length == 8'd0);

  assign w_sweep_apply = bus.hlf_en && (r_sw_div == 3'd0) && r_sw_en
                       && (r_sw_shift != 3'd0) && !w_mute;

  // Period: a CPU write always beats a sweep update landing in the same cycle
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (w_wr_r2 || w_wr_r3) begin
      if (w_wr_r2) begin
        r_period[7:0] <= bus.wr_data;
      end
      if (w_wr_r3) begin
        r_period[TIMER_W-1:8] <= bus.wr_data[TIMER_W-9:0];
      end
    end else if (w_sweep_apply) begin
      r_period <= w_target[TIMER_W-1:0];
    end
  end

  // Sweep divider; reload flag raised by an R1 write wins over its own clear
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_div    <= '0;
      r_sw_reload <= 1'b0;
    end else begin
      if (bus.hlf_en) begin
        if ((r_sw_div == 3'd0) || r_sw_reload) begin
          r_sw_div <= r_sw_per;
        end else begin
          r_sw_div <= r_sw_div - 3'd1;
        end
      end
      if (w_wr_r1) begin
        r_sw_reload <= 1'b1;
      end else if (bus.hlf_en && ((r_sw_div == 3'd0) || r_sw_reload)) begin
        r_sw_reload <= 1'b0;
      end
    end
  end

  // Timer and duty sequencer; an R3 write restarts the sequence at step 0
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_seq_idx <= '0;
    end else begin
      if (r_timer == '0) begin
        r_timer <= r_period;
      end else begin
        r_timer <= r_timer - TIMER_W'(1);
      end
      if (w_wr_r3) begin
        r_seq_idx <= '0;
      end else if (r_timer == '0) begin
        r_seq_idx <= r_seq_idx - 3'd1;
      end
    end
  end

  // Length counter: disable > reload > half-frame decrement
  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_length <= '0;
    end else if (!bus.ch_enable) begin
      r_length <= '0;
    end else if (w_wr_r3) begin
      r_length <= LENGTH_TABLE[bus.wr_data[R3_LEN_HI:R3_LEN_LO]];
    end else if (bus.hlf_en && !r_halt && (r_length != 8'd0)) begin
      r_length <= r_length - 8'd1;
    end
  end

  pulse_channel_gen2_envelope #(
    .VOL_W (VOL_W)
  ) u_envelope (
    .apu_clk     (apu_clk),
    .rst_n       (rst_n),
    .i_qtr_en    (bus.qtr_en),
    .i_start     (w_wr_r3),
    .i_halt      (r_halt),
    .i_const_vol (r_const_vol),
    .i_vol       (r_vol),
    .o_volume    (w_volume)
  );

  assign w_seq_bit = duty_bit(r_duty, r_seq_idx);
  assign w_mag     = {1'b0, w_volume};

  always_comb begin
    w_sample = '0;
    if (!w_mute) begin
      w_sample = w_seq_bit ? w_mag : (~w_mag + OUT_W'(1));
    end
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_sample;
    end
  end

  assign bus.pulse_out  = r_out;
  assign bus.len_active = (r_length != 8'd0);

endmodule
